// File: rtl/pico_ctrl_pkg.sv
// Shared opcode, state and ALU-function types plus instruction field positions
// for the pico control sequencer.
package pico_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADDI = 4'd1,
    OP_ADD  = 4'd2,
    OP_MULI = 4'd3,
    OP_MUL  = 4'd4,
    OP_WAIT = 4'd5,
    OP_BEQ  = 4'd6,
    OP_JMP  = 4'd7,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    WB      = 3'd3,
    WAIT_GO = 3'd4,
    HALT    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    FUNC_PASS = 2'b00,
    FUNC_ADD  = 2'b01,
    FUNC_MUL  = 2'b10,
    FUNC_RSVD = 2'b11
  } alu_func_t;

  localparam int OP_MSB  = 17;
  localparam int OP_LSB  = 14;
  localparam int RD_MSB  = 13;
  localparam int RD_LSB  = 11;
  localparam int RS_MSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/pico_ctrl_decode.sv
// Combinational opcode decode for the pico sequencer.
// BEQ/JMP are recognised only when PICO_CTRL_BRANCH_EN is defined.
module pico_ctrl_decode
  import pico_ctrl_pkg::*;
(
  input  logic [3:0] i_op,
  output logic       o_alu_flag,
  output logic [1:0] o_alu_func,
  output logic       o_is_alu,
  output logic       o_is_branch,
  output logic       o_is_wait,
  output logic       o_is_halt
);

  // Opcode to control-class decode; unknown opcodes fall through as NOP.
  always_comb begin
    o_alu_flag  = 1'b0;
    o_alu_func  = FUNC_PASS;
    o_is_alu    = 1'b0;
    o_is_branch = 1'b0;
    o_is_wait   = 1'b0;
    o_is_halt   = 1'b0;
    case (i_op)
      OP_ADDI: begin
        o_is_alu   = 1'b1;
        o_alu_func = FUNC_ADD;
      end
      OP_ADD: begin
        o_is_alu   = 1'b1;
        o_alu_flag = 1'b1;
        o_alu_func = FUNC_ADD;
      end
      OP_MULI: begin
        o_is_alu   = 1'b1;
        o_alu_func = FUNC_MUL;
      end
      OP_MUL: begin
        o_is_alu   = 1'b1;
        o_alu_flag = 1'b1;
        o_alu_func = FUNC_MUL;
      end
      OP_WAIT: o_is_wait = 1'b1;
`ifdef PICO_CTRL_BRANCH_EN
      OP_BEQ:  o_is_branch = 1'b1;
      OP_JMP:  o_is_branch = 1'b1;
`endif
      OP_HALT: o_is_halt = 1'b1;
      default: o_is_alu = 1'b0;
    endcase
  end

endmodule

// File: rtl/pico_ctrl_fsm.sv
// Multi-cycle instruction sequencer: fetch/decode FSM, program counter and go-button edge detect.
// Optional BEQ/JMP and zero flag enabled by defining PICO_CTRL_BRANCH_EN.
module pico_ctrl_fsm
  import pico_ctrl_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int REG_AW  = 3,
  parameter int INSTR_W = 18
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_alu_zero,
  input  logic               i_go,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_alu_flag,
  output logic [1:0]         o_alu_func,
  output logic [7:0]         o_prog_value,
  output logic [REG_AW-1:0]  o_raddr1,
  output logic [REG_AW-1:0]  o_raddr2,
  output logic [REG_AW-1:0]  o_waddr,
  output logic               o_ram_we,
  output logic               o_waiting,
  output logic               o_halted
);

  localparam logic [2:0] S_FETCH  = FETCH;
  localparam logic [2:0] S_DECODE = DECODE;
  localparam logic [2:0] S_EXEC   = EXEC;
  localparam logic [2:0] S_WB     = WB;
  localparam logic [2:0] S_WAIT   = WAIT_GO;
  localparam logic [2:0] S_HALT   = HALT;

  logic [2:0]         r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_go_q;
  logic               r_alu_flag;
  logic [1:0]         r_alu_func;
  logic [7:0]         r_prog_value;
  logic [REG_AW-1:0]  r_raddr1;
  logic [REG_AW-1:0]  r_raddr2;
  logic [REG_AW-1:0]  r_waddr;
  logic               r_ram_we;
  logic               r_waiting;
  logic               r_halted;
`ifdef PICO_CTRL_BRANCH_EN
  logic               r_z_flag;
`else
  logic               w_unused_alu_zero;
  assign w_unused_alu_zero = i_alu_zero;
`endif

  logic [3:0]      w_op;
  logic [7:0]      w_imm;
  logic            w_alu_flag;
  logic [1:0]      w_alu_func;
  logic            w_is_alu;
  logic            w_is_branch;
  logic            w_is_wait;
  logic            w_is_halt;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;

  assign w_op  = r_ir[OP_MSB:OP_LSB];
  assign w_imm = r_ir[IMM_MSB:IMM_LSB];

  pico_ctrl_decode u_decode (
    .i_op        (w_op),
    .o_alu_flag  (w_alu_flag),
    .o_alu_func  (w_alu_func),
    .o_is_alu    (w_is_alu),
    .o_is_branch (w_is_branch),
    .o_is_wait   (w_is_wait),
    .o_is_halt   (w_is_halt)
  );

  // Next pc for instructions that retire in DECODE (NOP, illegal, BEQ, JMP).
  always_comb begin
    w_pc_inc  = r_pc + PC_W'(1);
    w_pc_next = w_pc_inc;
`ifdef PICO_CTRL_BRANCH_EN
    if (w_is_branch) begin
      if (w_op == OP_JMP) begin
        w_pc_next = PC_W'(w_imm);
      end else if (r_z_flag) begin
        w_pc_next = r_pc + PC_W'($signed(w_imm));
      end else begin
        w_pc_next = w_pc_inc;
      end
    end else begin
      w_pc_next = w_pc_inc;
    end
`endif
  end

  // Sequencer state, pc and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_FETCH;
      r_pc         <= {PC_W{1'b0}};
      r_ir         <= {INSTR_W{1'b0}};
      r_go_q       <= 1'b0;
      r_alu_flag   <= 1'b0;
      r_alu_func   <= 2'b00;
      r_prog_value <= 8'd0;
      r_raddr1     <= {REG_AW{1'b0}};
      r_raddr2     <= {REG_AW{1'b0}};
      r_waddr      <= {REG_AW{1'b0}};
      r_ram_we     <= 1'b0;
      r_waiting    <= 1'b0;
      r_halted     <= 1'b0;
`ifdef PICO_CTRL_BRANCH_EN
      r_z_flag     <= 1'b0;
`endif
    end else begin
      r_go_q   <= i_go;
      r_ram_we <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_ir    <= i_instr;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_alu_flag   <= w_alu_flag;
          r_alu_func   <= w_alu_func;
          r_prog_value <= w_imm;
          r_raddr1     <= REG_AW'(r_ir[RD_MSB:RD_LSB]);
          r_raddr2     <= REG_AW'(r_ir[RS_MSB:RS_LSB]);
          r_waddr      <= REG_AW'(r_ir[RD_MSB:RD_LSB]);
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_is_wait) begin
            r_waiting <= 1'b1;
            r_state   <= S_WAIT;
          end else if (w_is_alu) begin
            r_state <= S_EXEC;
          end else begin
            r_pc    <= w_pc_next;
            r_state <= S_FETCH;
          end
        end
        S_EXEC: begin
          r_ram_we <= 1'b1;
          r_state  <= S_WB;
        end
        S_WB: begin
          r_pc    <= w_pc_inc;
`ifdef PICO_CTRL_BRANCH_EN
          r_z_flag <= i_alu_zero;
`endif
          r_state <= S_FETCH;
        end
        S_WAIT: begin
          // Only a fresh rising edge counts, so a button already held on entry is ignored.
          if (i_go && !r_go_q) begin
            r_pc      <= w_pc_inc;
            r_waiting <= 1'b0;
            r_state   <= S_FETCH;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign o_pc         = r_pc;
  assign o_alu_flag   = r_alu_flag;
  assign o_alu_func   = r_alu_func;
  assign o_prog_value = r_prog_value;
  assign o_raddr1     = r_raddr1;
  assign o_raddr2     = r_raddr2;
  assign o_waddr      = r_waddr;
  assign o_ram_we     = r_ram_we;
  assign o_waiting    = r_waiting;
  assign o_halted     = r_halted;

endmodule

// File: tb/tb_pico_ctrl_fsm.sv
// Self-checking bench for pico_ctrl_fsm: directed vector table, corner sequences
// and a random program checked against an instruction-level reference model.
module tb_pico_ctrl_fsm;

  localparam int PC_W    = 8;
  localparam int REG_AW  = 3;
  localparam int INSTR_W = 18;
  localparam int NCYC    = 600;
`ifdef PICO_CTRL_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               i_reset = 1'b1;
  logic [INSTR_W-1:0] i_instr;
  logic               i_alu_zero = 1'b0;
  logic               i_go = 1'b0;
  logic [PC_W-1:0]    o_pc;
  logic               o_alu_flag;
  logic [1:0]         o_alu_func;
  logic [7:0]         o_prog_value;
  logic [REG_AW-1:0]  o_raddr1, o_raddr2, o_waddr;
  logic               o_ram_we, o_waiting, o_halted;

  logic [INSTR_W-1:0] rom [256];
  assign i_instr = rom[o_pc];

  always #5 clk = ~clk;

  pico_ctrl_fsm #(.PC_W(PC_W), .REG_AW(REG_AW), .INSTR_W(INSTR_W)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_instr      (i_instr),
    .i_alu_zero   (i_alu_zero),
    .i_go         (i_go),
    .o_pc         (o_pc),
    .o_alu_flag   (o_alu_flag),
    .o_alu_func   (o_alu_func),
    .o_prog_value (o_prog_value),
    .o_raddr1     (o_raddr1),
    .o_raddr2     (o_raddr2),
    .o_waddr      (o_waddr),
    .o_ram_we     (o_ram_we),
    .o_waiting    (o_waiting),
    .o_halted     (o_halted)
  );

  typedef struct {
    logic [17:0] instr;
    logic        flag;
    logic [1:0]  func;
    logic [7:0]  prog;
    logic [2:0]  r1, r2, wa;
    int          lat;
    int          pc_after;
    int          we_cnt;
    int          we_cyc;
  } vec_t;

  vec_t        vq[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [30:0] exp_tr [NCYC];
  bit          zbits [NCYC];
  int          ops [10] = '{0, 1, 2, 3, 4, 6, 7, 8, 11, 14};

  function automatic logic [17:0] mk(input int op, input int rd, input int rs, input int imm);
    return {op[3:0], rd[2:0], rs[2:0], imm[7:0]};
  endfunction

  function automatic vec_t mkv(input logic [17:0] w, input logic f, input logic [1:0] fn,
                               input logic [7:0] p, input logic [2:0] a1, input logic [2:0] a2,
                               input logic [2:0] aw, input int lat, input int pca,
                               input int wc, input int wy);
    vec_t v;
    v.instr = w; v.flag = f; v.func = fn; v.prog = p; v.r1 = a1; v.r2 = a2; v.wa = aw;
    v.lat = lat; v.pc_after = pca; v.we_cnt = wc; v.we_cyc = wy;
    return v;
  endfunction

  // Architectural decode: {alu_flag, alu_func, imm, rd, rs, rd}
  function automatic logic [19:0] dec(input logic [17:0] w);
    logic [3:0] op;
    logic       f;
    logic [1:0] fn;
    op = w[17:14];
    f  = (op == 4'd2 || op == 4'd4);
    fn = (op == 4'd1 || op == 4'd2) ? 2'd1 : (op == 4'd3 || op == 4'd4) ? 2'd2 : 2'd0;
    return {f, fn, w[7:0], w[13:11], w[10:8], w[13:11]};
  endfunction

  function automatic logic [30:0] dut_vec();
    return {o_waiting, o_halted, o_pc, o_ram_we, o_alu_flag, o_alu_func,
            o_prog_value, o_raddr1, o_raddr2, o_waddr};
  endfunction

  function automatic void put(input int idx, input int pc, input logic we, input logic [19:0] d);
    logic [7:0] p;
    p = pc[7:0];
    if (idx < NCYC) exp_tr[idx] = {1'b0, 1'b0, p, we, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1 time unit into the first FETCH cycle after reset.
  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 18'd0;
  endtask

  // Instruction-level model: ALU ops take 4 cycles with the write strobe in the
  // last one, everything else 2 cycles; decoded fields appear after DECODE.
  task automatic build_model();
    int          t;
    int          pc;
    bit          z;
    int          op;
    logic [19:0] d;
    logic [19:0] dn;
    logic [17:0] w;
    t = 0; pc = 0; z = 1'b0; d = 20'd0;
    while (t < NCYC) begin
      w  = rom[pc];
      op = int'(w[17:14]);
      dn = dec(w);
      put(t, pc, 1'b0, d);
      put(t + 1, pc, 1'b0, d);
      if (op >= 1 && op <= 4) begin
        put(t + 2, pc, 1'b0, dn);
        put(t + 3, pc, 1'b1, dn);
        if (t + 3 < NCYC) z = zbits[t + 3];
        pc = (pc + 1) % 256;
        t  = t + 4;
      end else begin
        if (BR && op == 7) pc = int'(w[7:0]);
        else if (BR && op == 6 && z) pc = (pc + int'($signed(w[7:0]))) & 255;
        else pc = (pc + 1) % 256;
        t = t + 2;
      end
      d = dn;
    end
  endtask

  task automatic beq_case(input bit zval, input int exp_pc, input string nm);
    clear_rom();
    rom[0] = mk(1, 1, 0, 1);
    rom[2] = mk(6, 0, 0, 8'hFE);
    i_alu_zero = zval;
    do_reset();
    step(6);
    chk({nm, "_pc_at_beq"}, 32'(o_pc), 32'd2);
    step(2);
    chk({nm, "_pc_after"}, 32'(o_pc), 32'(exp_pc));
  endtask

  initial begin
    int wec;
    int wecyc;

    vq.push_back(mkv(mk(1, 2, 0, 5),     1'b0, 2'd1, 8'd5,   3'd2, 3'd0, 3'd2, 4, 1, 1, 3));
    vq.push_back(mkv(mk(4, 1, 3, 0),     1'b1, 2'd2, 8'd0,   3'd1, 3'd3, 3'd1, 4, 1, 1, 3));
    vq.push_back(mkv(mk(2, 7, 6, 165),   1'b1, 2'd1, 8'd165, 3'd7, 3'd6, 3'd7, 4, 1, 1, 3));
    vq.push_back(mkv(mk(3, 0, 5, 255),   1'b0, 2'd2, 8'd255, 3'd0, 3'd5, 3'd0, 4, 1, 1, 3));
    vq.push_back(mkv(mk(0, 3, 4, 18),    1'b0, 2'd0, 8'd18,  3'd3, 3'd4, 3'd3, 2, 1, 0, -1));
    vq.push_back(mkv(mk(9, 5, 1, 119),   1'b0, 2'd0, 8'd119, 3'd5, 3'd1, 3'd5, 2, 1, 0, -1));
    vq.push_back(mkv(mk(14, 6, 2, 200),  1'b0, 2'd0, 8'd200, 3'd6, 3'd2, 3'd6, 2, 1, 0, -1));
    vq.push_back(mkv(mk(7, 2, 3, 64),    1'b0, 2'd0, 8'd64,  3'd2, 3'd3, 3'd2, 2, BR ? 64 : 1, 0, -1));
    vq.push_back(mkv(mk(6, 1, 1, 16),    1'b0, 2'd0, 8'd16,  3'd1, 3'd1, 3'd1, 2, 1, 0, -1));

    clear_rom();
    do_reset();
    chk("reset_outputs", 32'(dut_vec()), 32'd0);

    foreach (vq[i]) begin
      clear_rom();
      rom[0] = vq[i].instr;
      do_reset();
      wec = 0;
      wecyc = -1;
      for (int c = 0; c <= vq[i].lat + 1; c++) begin
        if (c == 2) begin
          chk($sformatf("vec%0d_flag", i), 32'(o_alu_flag), 32'(vq[i].flag));
          chk($sformatf("vec%0d_func", i), 32'(o_alu_func), 32'(vq[i].func));
          chk($sformatf("vec%0d_prog", i), 32'(o_prog_value), 32'(vq[i].prog));
          chk($sformatf("vec%0d_raddr1", i), 32'(o_raddr1), 32'(vq[i].r1));
          chk($sformatf("vec%0d_raddr2", i), 32'(o_raddr2), 32'(vq[i].r2));
          chk($sformatf("vec%0d_waddr", i), 32'(o_waddr), 32'(vq[i].wa));
        end
        if (c == vq[i].lat) chk($sformatf("vec%0d_pc", i), 32'(o_pc), 32'(vq[i].pc_after));
        if (o_ram_we) begin
          wec++;
          wecyc = c;
        end
        step(1);
      end
      chk($sformatf("vec%0d_we_cnt", i), 32'(wec), 32'(vq[i].we_cnt));
      chk($sformatf("vec%0d_we_cyc", i), 32'(wecyc), 32'(vq[i].we_cyc));
    end

    // WAIT: a held button is ignored until it drops and rises again.
    clear_rom();
    rom[0] = mk(5, 0, 0, 0);
    i_go = 1'b1;
    do_reset();
    step(2);
    chk("wait_enter", 32'({o_waiting, o_pc}), 32'({1'b1, 8'd0}));
    step(10);
    chk("wait_held_go", 32'({o_waiting, o_pc}), 32'({1'b1, 8'd0}));
    i_go = 1'b0;
    step(3);
    chk("wait_go_low", 32'({o_waiting, o_pc}), 32'({1'b1, 8'd0}));
    i_go = 1'b1;
    chk("wait_edge_cycle", 32'(o_pc), 32'd0);
    step(1);
    chk("wait_exit", 32'({o_waiting, o_pc}), 32'({1'b0, 8'd1}));
    i_go = 1'b0;

    beq_case(1'b1, BR ? 0 : 3, "beq_z1");
    beq_case(1'b0, 3, "beq_z0");
    i_alu_zero = 1'b0;

    // pc wrap through 255 followed by HALT at address 0.
    clear_rom();
    do_reset();
    step(2);
    rom[0] = mk(15, 0, 0, 0);
    step(508);
    chk("wrap_pc255", 32'(o_pc), 32'd255);
    step(2);
    chk("wrap_pc0", 32'(o_pc), 32'd0);
    step(2);
    chk("halt_enter", 32'(o_halted), 32'd1);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("halt_hold%0d", k), 32'({o_pc, o_ram_we, o_halted, o_waiting}),
          32'({8'd0, 1'b0, 1'b1, 1'b0}));
      step(1);
    end

    // Reset during EXEC of ADD aborts the write.
    clear_rom();
    rom[0] = mk(2, 1, 2, 9);
    do_reset();
    step(2);
    i_reset = 1'b1;
    step(1);
    chk("rst_exec_outputs", 32'(dut_vec()), 32'd0);
    step(1);
    chk("rst_exec_no_we", 32'({o_ram_we, o_pc}), 32'd0);
    i_reset = 1'b0;

    // Random program against the instruction-level model.
    for (int a = 0; a < 256; a++)
      rom[a] = mk(ops[$urandom_range(0, 9)], int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    for (int c = 0; c < NCYC; c++) zbits[c] = 1'($urandom_range(0, 1));
    build_model();
    do_reset();
    for (int c = 0; c < NCYC; c++) begin
      i_alu_zero = zbits[c];
      chk($sformatf("rand_c%0d", c), 32'(dut_vec()), 32'(exp_tr[c]));
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
